// File: rtl/blinkled_progmem_arbiter.sv
// Round-robin sharing of the single-port program memory between instruction
// fetch (m0, read-only) and the data/loader port (m1), with range checking.
module blinkled_progmem_arbiter #(
    parameter int          ADDR_W = 16,
    parameter int          DATA_W = 32,
    parameter int          BE_W   = 4,
    parameter int unsigned DEPTH  = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_req,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              err_clear,
    output logic              err_sticky,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic {
        RR_M0 = 1'b0,
        RR_M1 = 1'b1
    } rr_t;

    // One extra bit so a DEPTH equal to 2**ADDR_W never flags anything.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    rr_t               rr;
    logic              m0_req_raw;
    logic              m1_req_raw;
    logic              m0_req;
    logic              m1_req;
    logic              grant0;
    logic              grant1;
    logic [ADDR_W-1:0] win_addr;
    logic              win_oor;
    logic              win_write;
    logic              rv0;
    logic              rv1;
    logic              oor_q;

    always_comb begin
        m0_req_raw = m0_read;
        m1_req_raw = m1_read | m1_write;
        m0_req     = m0_req_raw & ~reset_req;
        m1_req     = m1_req_raw & ~reset_req;

        grant0 = m0_req & (~m1_req | (rr == RR_M0));
        grant1 = m1_req & (~m0_req | (rr == RR_M1));

        m0_waitrequest = m0_req_raw & ~grant0;
        m1_waitrequest = m1_req_raw & ~grant1;

        win_addr  = grant1 ? m1_address : (grant0 ? m0_address : '0);
        win_oor   = (grant0 | grant1) & ({1'b0, win_addr} >= LIMIT);
        win_write = grant1 & m1_write;

        mem_address    = win_addr;
        mem_byteenable = grant1 ? m1_byteenable : (grant0 ? '1 : '0);
        mem_writedata  = grant1 ? m1_writedata : '0;
        mem_chipselect = (grant0 | grant1) & ~win_oor;
        mem_write      = win_write & ~win_oor;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr         <= RR_M0;
            rv0        <= 1'b0;
            rv1        <= 1'b0;
            oor_q      <= 1'b0;
            err_sticky <= 1'b0;
            err_addr   <= '0;
        end else begin
            if (grant0) begin
                rr <= RR_M1;
            end else if (grant1) begin
                rr <= RR_M0;
            end
            rv0   <= grant0;
            rv1   <= grant1 & ~m1_write;
            oor_q <= win_oor;
            // A new error in the same cycle as err_clear re-arms the capture.
            if (win_oor) begin
                err_sticky <= 1'b1;
                if (!err_sticky || err_clear) begin
                    err_addr <= win_addr;
                end
            end else if (err_clear) begin
                err_sticky <= 1'b0;
            end
        end
    end

    always_comb begin
        m0_readdatavalid = rv0;
        m1_readdatavalid = rv1;
        m0_readdata      = (rv0 && !oor_q) ? mem_readdata : '0;
        m1_readdata      = (rv1 && !oor_q) ? mem_readdata : '0;
    end

endmodule
